// File: rtl/vga_scan_controller_pkg.sv
// Shared timing defaults and types for the VGA scan controller slice.
// Timing values describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
  } rgb_t;

  // Inclusive range test used by the sync decoders.
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Coordinate -> colour bus between the scan controller and the color mapper.
interface vga_scan_controller_if;
  import vga_pkg::*;

  // No valid/ready: ReadX/ReadY are held for a whole pixel period and the
  // mapper must return PixR/G/B combinationally within that same period;
  // the controller samples the colour on the cycle PixelTick is high.
  coord_t     ReadX;
  coord_t     ReadY;
  logic       PixelTick;
  logic       LineStart;
  logic       FrameStart;
  logic [7:0] PixR;
  logic [7:0] PixG;
  logic [7:0] PixB;

  modport master (
    output ReadX, ReadY, PixelTick, LineStart, FrameStart,
    input  PixR, PixG, PixB
  );

  modport slave (
    input  ReadX, ReadY, PixelTick, LineStart, FrameStart,
    output PixR, PixG, PixB
  );

endinterface

// File: rtl/vga_scan_controller_tick_gen.sv
// Clock divider: one PixelTick per CLK_DIV system clocks plus the DAC pixel clock.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick,
  output logic o_vga_clk
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_vga_clk;

  always_comb begin
    w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    if (!i_enable) w_div_next = '0;
  end

  // VGA_CLK is registered from the next divider value so it lines up with r_div.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_vga_clk <= (w_div_next >= DIV_HALF);
    end
  end

  assign o_tick    = (r_div == DIV_LAST);
  assign o_vga_clk = r_vga_clk;

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster timing: pixel counters, sync/blank decode and a one-pixel-delayed
// output stage that keeps colour, HS, VS and BLANK aligned at the DAC.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         Enable,
  vga_scan_controller_if.master        pix_bus,
  output logic                         VGA_CLK,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic                         VGA_BLANK_N,
  output logic                         VGA_SYNC_N,
  output logic [7:0]                   VGA_R,
  output logic [7:0]                   VGA_G,
  output logic [7:0]                   VGA_B
);

  localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(HT - 1);
  localparam coord_t V_LAST   = coord_t'(VT - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic   w_tick;
  logic   w_vga_clk;
  coord_t r_hcount;
  coord_t r_vcount;
  logic   w_hs_act;
  logic   w_vs_act;
  logic   w_visible;
  rgb_t   w_rgb;
  logic   r_hs;
  logic   r_vs;
  logic   r_blank_n;
  rgb_t   r_rgb;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk     (Clk),
    .i_rst_n   (Reset_n),
    .i_enable  (Enable),
    .o_tick    (w_tick),
    .o_vga_clk (w_vga_clk)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (!Enable) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_tick) begin
      if (r_hcount == H_LAST) begin
        r_hcount <= '0;
        r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
        r_hcount <= r_hcount + 1'b1;
      end
    end
  end

  always_comb begin
    w_hs_act  = in_range(r_hcount, HS_FIRST, HS_LAST);
    w_vs_act  = in_range(r_vcount, VS_FIRST, VS_LAST);
    w_visible = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    w_rgb     = '0;
    if (w_visible) w_rgb = '{R: pix_bus.PixR, G: pix_bus.PixG, B: pix_bus.PixB};
  end

  // Output stage samples the decode of the coordinate being consumed, so every
  // DAC-side signal trails ReadX/ReadY by exactly one pixel period.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (!Enable) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (w_tick) begin
      r_hs      <= ~w_hs_act;
      r_vs      <= ~w_vs_act;
      r_blank_n <= w_visible;
      r_rgb     <= w_rgb;
    end
  end

  assign pix_bus.ReadX      = r_hcount;
  assign pix_bus.ReadY      = r_vcount;
  assign pix_bus.PixelTick  = w_tick;
  assign pix_bus.LineStart  = w_tick && (r_hcount == '0);
  assign pix_bus.FrameStart = w_tick && (r_hcount == '0) && (r_vcount == '0);

  assign VGA_CLK     = w_vga_clk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_rgb.R;
  assign VGA_G       = r_rgb.G;
  assign VGA_B       = r_rgb.B;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: full horizontal timing, shortened frame height
// so whole frames fit in a short run.
module tb_vga_scan_controller;
  import vga_pkg::*;

  localparam int CD  = 2;
  localparam int HV  = 640;
  localparam int HF  = 16;
  localparam int HSW = 96;
  localparam int HB  = 48;
  localparam int VV  = 4;
  localparam int VF  = 1;
  localparam int VSW = 2;
  localparam int VB  = 1;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  logic       vga_clk, hs, vs, blank_n, sync_n;
  logic [7:0] vr, vg, vb;

  vga_scan_controller_if bus ();
  assign bus.PixR = bus.ReadX[7:0];
  assign bus.PixG = bus.ReadY[7:0];
  assign bus.PixB = 8'hA5;

  vga_scan_controller #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .CLK_DIV   (CD)
  ) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Enable      (enable),
    .pix_bus     (bus),
    .VGA_CLK     (vga_clk),
    .VGA_HS      (hs),
    .VGA_VS      (vs),
    .VGA_BLANK_N (blank_n),
    .VGA_SYNC_N  (sync_n),
    .VGA_R       (vr),
    .VGA_G       (vg),
    .VGA_B       (vb)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: n = clocks scanned since the raster last restarted at (0,0).
  int n = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       n <= 0;
    else if (!enable) n <= 0;
    else              n <= n + 1;
  end

  always @(negedge clk) begin : cmp
    int p, d, x, y, q, qx, qy;
    logic vis, ehs, evs, etick;
    p = n / CD;
    d = n % CD;
    x = p % HT;
    y = (p / HT) % VT;
    etick = (d == CD - 1);
    qx = 0; qy = 0; vis = 1'b0; ehs = 1'b1; evs = 1'b1;
    if (p > 0) begin
      q   = p - 1;
      qx  = q % HT;
      qy  = (q / HT) % VT;
      vis = (qx < HV) && (qy < VV);
      ehs = !((qx >= HV + HF) && (qx < HV + HF + HSW));
      evs = !((qy >= VV + VF) && (qy < VV + VF + VSW));
    end
    chk("m_readx",  32'(bus.ReadX), 32'(x));
    chk("m_ready",  32'(bus.ReadY), 32'(y));
    chk("m_tick",   32'(bus.PixelTick), 32'(etick));
    chk("m_line",   32'(bus.LineStart), 32'(etick && x == 0));
    chk("m_frame",  32'(bus.FrameStart), 32'(etick && x == 0 && y == 0));
    chk("m_vgaclk", 32'(vga_clk), 32'(d >= CD / 2));
    chk("m_hs",     32'(hs), 32'(ehs));
    chk("m_vs",     32'(vs), 32'(evs));
    chk("m_blank",  32'(blank_n), 32'(vis));
    chk("m_r",      32'(vr), vis ? 32'(qx % 256) : 32'd0);
    chk("m_g",      32'(vg), vis ? 32'(qy % 256) : 32'd0);
    chk("m_b",      32'(vb), vis ? 32'hA5 : 32'd0);
    chk("m_syncn",  32'(sync_n), 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_xy(input int x, input int y, input int lim, input string name);
    int i;
    for (i = 0; i < lim; i++) begin
      if (int'(bus.ReadX) == x && int'(bus.ReadY) == y) break;
      @(negedge clk);
    end
    chk(name, 32'(i < lim), 32'd1);
  endtask

  task automatic wait_sig_line(input int lim, output int at);
    int i;
    for (i = 0; i < lim; i++) begin
      if (bus.LineStart) break;
      @(negedge clk);
    end
    chk("wait_linestart", 32'(i < lim), 32'd1);
    at = cyc;
  endtask

  task automatic wait_sig_frame(input int lim, output int at);
    int i;
    for (i = 0; i < lim; i++) begin
      if (bus.FrameStart) break;
      @(negedge clk);
    end
    chk("wait_framestart", 32'(i < lim), 32'd1);
    at = cyc;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, t1, cnt, i;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_blank", 32'(blank_n), 32'd0);
    chk("rst_readx", 32'(bus.ReadX), 32'd0);
    chk("rst_tick", 32'(bus.PixelTick), 32'd0);
    chk("rst_vgaclk", 32'(vga_clk), 32'd0);
    chk("rst_r", 32'(vr), 32'd0);

    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tick_c1", 32'(bus.PixelTick), 32'd0);
    @(negedge clk);
    chk("rel_tick_c2", 32'(bus.PixelTick), 32'd1);
    chk("rel_frame_c2", 32'(bus.FrameStart), 32'd1);
    @(negedge clk);
    chk("rel_readx", 32'(bus.ReadX), 32'd1);
    chk("rel_blank", 32'(blank_n), 32'd1);
    chk("rel_b", 32'(vb), 32'hA5);

    wait_xy(101, 2, 10000, "reach_101_2");
    chk("col_r", 32'(vr), 32'd100);
    chk("col_g", 32'(vg), 32'd2);
    chk("col_blank", 32'(blank_n), 32'd1);
    wait_xy(641, 2, 2000, "reach_641_2");
    chk("hblank_r", 32'(vr), 32'd0);
    chk("hblank_n", 32'(blank_n), 32'd0);
    wait_xy(656, 2, 100, "reach_656");
    chk("hs_before", 32'(hs), 32'd1);
    wait_xy(657, 2, 10, "reach_657");
    chk("hs_fall", 32'(hs), 32'd0);
    cnt = 0;
    for (i = 0; i < 400 && hs == 1'b0; i++) begin
      if (bus.PixelTick) cnt++;
      @(negedge clk);
    end
    chk("hs_low_periods", 32'(cnt), 32'd96);
    chk("hs_rise_x", 32'(bus.ReadX), 32'd753);

    wait_sig_line(4000, t0);
    @(negedge clk);
    wait_sig_line(4000, t1);
    chk("line_period", 32'(t1 - t0), 32'd1600);

    wait_xy(11, VV, 8000, "reach_11_vv");
    chk("vblank_n", 32'(blank_n), 32'd0);
    chk("vblank_g", 32'(vg), 32'd0);

    wait_sig_frame(30000, t0);
    @(negedge clk);
    wait_sig_frame(30000, t1);
    chk("frame_period", 32'(t1 - t0), 32'(HT * VT * CD));

    for (i = 0; i < 20000 && vs == 1'b1; i++) @(negedge clk);
    chk("vs_fall_y", 32'(bus.ReadY), 32'(VV + VF));
    chk("vs_fall_x", 32'(bus.ReadX), 32'd1);
    cnt = 0;
    for (i = 0; i < 8000 && vs == 1'b0; i++) begin
      if (bus.PixelTick) cnt++;
      @(negedge clk);
    end
    chk("vs_low_periods", 32'(cnt), 32'(VSW * HT));

    wait_xy(300, 2, 20000, "reach_300_2");
    @(posedge clk); #2 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_readx", 32'(bus.ReadX), 32'd0);
    chk("dis_ready", 32'(bus.ReadY), 32'd0);
    chk("dis_hs", 32'(hs), 32'd1);
    chk("dis_vs", 32'(vs), 32'd1);
    chk("dis_blank", 32'(blank_n), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 enable = 1'b1;
    @(negedge clk);
    chk("en_frame_c1", 32'(bus.FrameStart), 32'd0);
    @(negedge clk);
    chk("en_frame_c2", 32'(bus.FrameStart), 32'd1);

    wait_xy(655, 0, 4000, "reach_655");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_readx", 32'(bus.ReadX), 32'd0);
    chk("arst_tick", 32'(bus.PixelTick), 32'd0);
    chk("arst_hs", 32'(hs), 32'd1);
    chk("arst_blank", 32'(blank_n), 32'd0);
    chk("arst_vgaclk", 32'(vga_clk), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_hold_hs", 32'(hs), 32'd1);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (1700) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Generates VGA raster timing and the pixel coordinates (ReadX, ReadY) consumed by the color mapper. It registers the mapper's returned RGB alongside the sync and blank signals so that colour, HS, VS and BLANK reach the DAC aligned. It sits between the color mapper and the board VGA pins, at the far end of the coordinate → colour interface.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel; even, ≥2

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Enable  in  1  scan enable; low forces idle/blank
PixR, PixG, PixB  in  8 each  colour from color mapper for the current ReadX/ReadY
ReadX, ReadY  out  10 each  current pixel coordinate (hcount/vcount)
PixelTick  out  1  one-Clk pulse per pixel period
LineStart  out  1  one-Clk pulse on the tick where hcount==0
FrameStart  out  1  one-Clk pulse on the tick where hcount==0 and vcount==0
VGA_CLK  out  1  pixel clock to DAC
VGA_HS, VGA_VS  out  1 each  syncs, active low
VGA_BLANK_N  out  1  low during blanking
VGA_SYNC_N  out  1  tied 0
VGA_R, VGA_G, VGA_B  out  8 each  registered colour

Behaviour:
- One clock, Clk. Reset is asynchronous and active-low (Reset_n). All state is cleared on the Reset_n falling edge, independent of Clk.
- Reset values:
  - divider counter 0, hcount 0, vcount 0, PixelTick 0, LineStart 0, FrameStart 0, VGA_CLK 0
  - VGA_HS 1, VGA_VS 1, VGA_BLANK_N 0, VGA_R/G/B 0
- Divider:
  - div counts 0..CLK_DIV-1 and wraps; PixelTick=1 when div==CLK_DIV-1.
  - VGA_CLK = (div >= CLK_DIV/2), registered.
- Counters:
  - H_TOTAL = sum of the H params (800); V_TOTAL = sum of the V params (525).
  - On each PixelTick: hcount++; at H_TOTAL-1 it wraps to 0 and vcount++.
  - vcount wraps from V_TOTAL-1 to 0 when hcount wraps.
  - The counters change only on PixelTick.
- ReadX=hcount, ReadY=vcount, driven straight from registers and stable for the whole pixel period. PixR/G/B are expected combinationally within that period.
- Decode, combinational from the current counters:
  - hs_act: hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]
  - vs_act: vcount in [490,491]
  - visible: hcount<H_VISIBLE && vcount<V_VISIBLE
- Output stage, updated only on PixelTick:
  - VGA_HS=~hs_act, VGA_VS=~vs_act, VGA_BLANK_N=visible
  - VGA_R/G/B = visible ? Pix* : 0
  - Latency: outputs during pixel period k reflect the coordinate presented during period k-1. Syncs, blank and colour share that same one-period delay.
- LineStart and FrameStart are asserted in the same Clk cycle as PixelTick when their condition holds on the pre-increment counters.
- Enable low, synchronous:
  - next Clk: div, hcount and vcount go to 0; tick and start pulses go to 0
  - outputs take idle values: HS/VS 1, BLANK_N 0, RGB 0
  - An Enable drop mid-frame follows the same rule.
- Enable rising: the first PixelTick occurs CLK_DIV cycles later and consumes (0,0), with FrameStart=1.
- Reset_n asserted mid-operation: immediate return to the reset values. Scanning resumes from (0,0) after release, provided Enable is high.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams and derived H_TOTAL/V_TOTAL
  - typedef coord_t = logic [9:0]
  - typedef rgb_t = struct {R,G,B: logic [7:0]}
- Sub-module pixel_tick_gen (parameter CLK_DIV) owns the divider and produces PixelTick and VGA_CLK. Counters, decode and the output stage stay in the top module.

Test Plan:
- Reset_n=0 with Enable=1 → all outputs hold their reset values; release → first PixelTick after 2 Clk and FrameStart=1 on it; ReadX=1 after that tick.
- Free run for 2 lines → LineStart period is exactly 1600 Clk; VGA_HS low for exactly 96 pixel periods, falling one period after ReadX=656 is presented.
- Free run for 2 frames → FrameStart period is 840000 Clk; VGA_VS low for exactly 1600 pixel periods (2 lines), starting one period after ReadY=490, ReadX=0.
- Drive PixR=ReadX[7:0], PixG=ReadY[7:0], PixB=8'hA5 → in period k, VGA_R equals the ReadX of period k-1 while visible; at ReadX 640..799 and ReadY≥480, VGA_R/G/B=0 and BLANK_N=0.
- Drop Enable at ReadX=300, ReadY=200 → next Clk: ReadX=ReadY=0, HS=VS=1, BLANK_N=0; re-raise → FrameStart after 2 Clk.
- Pulse Reset_n low asynchronously mid-pixel at ReadX=655 → outputs return to reset values without waiting for a Clk edge; no partial HS pulse is produced.
